// File: rtl/lut_builder.sv
// Runtime-programmable key/value table feeding a mux_key i_lut bus; writes land one cycle after handshake, one write per 2 cycles.
// Ready drops during COMMIT and while i_clr is high. Define LUT_BUILDER_OVERWRITE_EN to update matching keys in place instead of appending.
module lut_builder #(
  parameter int KEY_NUM   = 4,
  parameter int KEY_WIDTH = 4,
  parameter int VAL_WIDTH = 8
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst_n,
  input  logic                                     i_clr,
  input  logic                                     i_wr_vld,
  output logic                                     o_wr_rdy,
  input  logic [KEY_WIDTH-1:0]                     i_wr_key,
  input  logic [VAL_WIDTH-1:0]                     i_wr_val,
  output logic                                     o_wr_done,
  output logic                                     o_wr_err,
  output logic [$clog2(KEY_NUM+1)-1:0]             o_cnt,
  output logic                                     o_full,
  output logic [KEY_NUM*(KEY_WIDTH+VAL_WIDTH)-1:0] o_lut
);

  localparam int EW = KEY_WIDTH + VAL_WIDTH;
  localparam int CW = $clog2(KEY_NUM + 1);

  typedef enum logic {S_IDLE, S_COMMIT} state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [EW-1:0]          r_ent [KEY_NUM];
  logic [CW-1:0]          r_cnt;
  logic [KEY_WIDTH-1:0]   r_key;
  logic [VAL_WIDTH-1:0]   r_val;
  logic [CW-1:0]          r_idx;
  logic                   r_rej;
  logic                   r_match;
  logic                   w_hs;
  logic                   w_full;
  logic                   w_commit;
  logic                   w_match;
  logic [CW-1:0]          w_match_idx;

  assign w_full = (r_cnt == CW'(KEY_NUM));
  assign w_hs   = i_wr_vld && o_wr_rdy;

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    if (i_clr) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (i_wr_vld) w_next = S_COMMIT;
        S_COMMIT: w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // outputs; a clear in COMMIT aborts the pending write silently
  always_comb begin
    o_wr_rdy  = 1'b0;
    o_wr_done = 1'b0;
    o_wr_err  = 1'b0;
    w_commit  = 1'b0;
    case (r_state)
      S_IDLE:   o_wr_rdy = !i_clr;
      S_COMMIT: begin
        o_wr_done = !i_clr && !r_rej;
        o_wr_err  = !i_clr &&  r_rej;
        w_commit  = !i_clr && !r_rej;
      end
      default:  o_wr_rdy = 1'b0;
    endcase
  end

`ifdef LUT_BUILDER_OVERWRITE_EN
  // descending scan so the lowest valid matching index wins
  always_comb begin
    w_match     = 1'b0;
    w_match_idx = '0;
    for (int i = KEY_NUM - 1; i >= 0; i--) begin
      if (i < int'(r_cnt) && r_ent[i][EW-1:VAL_WIDTH] == i_wr_key) begin
        w_match     = 1'b1;
        w_match_idx = CW'(i);
      end
    end
  end
`else
  assign w_match     = 1'b0;
  assign w_match_idx = '0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_key   <= '0;
      r_val   <= '0;
      r_idx   <= '0;
      r_rej   <= 1'b0;
      r_match <= 1'b0;
    end else if (w_hs) begin
      r_key   <= i_wr_key;
      r_val   <= i_wr_val;
      r_idx   <= w_match ? w_match_idx : r_cnt;
      r_rej   <= w_full && !w_match;
      r_match <= w_match;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      for (int i = 0; i < KEY_NUM; i++) r_ent[i] <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
      for (int i = 0; i < KEY_NUM; i++) r_ent[i] <= '0;
    end else if (w_commit) begin
      for (int i = 0; i < KEY_NUM; i++) begin
        if (i == int'(r_idx)) r_ent[i] <= {r_key, r_val};
      end
      if (!r_match) r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_full = w_full;

  for (genvar g = 0; g < KEY_NUM; g++) begin : g_pack
    assign o_lut[g*EW +: EW] = r_ent[g];
  end

endmodule

// File: doc/lut_builder.md
Name: lut_builder

Overview:
- Runtime writer for the flat key/value lookup bus consumed by the mux_key/mux lookup blocks.
- Accepts key/value pairs over a valid/ready write port and stores them in a register array.
- Drives a packed LUT vector that connects directly to a mux_key i_lut input, plus entry count and status flags.
- Used where decode tables are programmed at runtime instead of fixed at elaboration.

Parameters:
- KEY_NUM, 4: number of LUT entries (>=1).
- KEY_WIDTH, 4: key width in bits.
- VAL_WIDTH, 8: value width in bits.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_clr  input  1  synchronous clear of all entries.
- i_wr_vld  input  1  write request valid.
- o_wr_rdy  output  1  write port ready.
- i_wr_key  input  KEY_WIDTH  key to write.
- i_wr_val  input  VAL_WIDTH  value to write.
- o_wr_done  output  1  one-cycle pulse: write committed.
- o_wr_err  output  1  one-cycle pulse: write rejected, table full.
- o_cnt  output  $clog2(KEY_NUM+1)  number of valid entries.
- o_full  output  1  o_cnt == KEY_NUM.
- o_lut  output  KEY_NUM*(KEY_WIDTH+VAL_WIDTH)  packed table.

Behaviour:
- Packing of o_lut:
  - Entry i occupies bits [(i+1)*(KEY_WIDTH+VAL_WIDTH)-1 : i*(KEY_WIDTH+VAL_WIDTH)].
  - Within an entry, the key is in the upper KEY_WIDTH bits and the value in the lower VAL_WIDTH bits.
  - Entry 0 is at the LSBs.
  - Entries with index >= o_cnt read as all zeros.
  - o_lut is driven directly from registers, with no combinational path from inputs.
- Reset (i_rst_n low, asynchronous): all entries zero, o_cnt=0, o_full=0, o_wr_done=0, o_wr_err=0, FSM=IDLE, o_wr_rdy=1.
- FSM states and transitions:
  - IDLE: o_wr_rdy=1. If i_wr_vld, capture key/val, compute the match index and full status, and go to COMMIT.
  - COMMIT: o_wr_rdy=0. Apply the write, pulse done or err for this cycle, return to IDLE.
- Write timing:
  - Handshake completes when i_wr_vld && o_wr_rdy.
  - The write is visible on o_lut/o_cnt one cycle after the handshake, i.e. at the end of COMMIT.
  - Maximum throughput is one write per 2 cycles.
- Write rule (without overwrite feature):
  - Append at index o_cnt and increment o_cnt; pulse o_wr_done.
  - If o_full, the table is unchanged; pulse o_wr_err instead.
- Duplicate keys:
  - Duplicates are stored as separate entries.
  - The downstream mux gives priority to the lower index, so later duplicates are shadowed.
- Clear (i_clr):
  - Zeroes all entries and sets o_cnt=0.
  - Has priority over any write; a write pending in COMMIT is aborted with no done/err pulse.
  - FSM returns to IDLE.
  - A handshake in the same cycle as i_clr is not accepted: o_wr_rdy is forced to 0 while i_clr is high.
- Inputs captured at handshake: i_wr_key/i_wr_val are only sampled at handshake; changes afterwards do not affect the pending write.
- Pulse exclusivity: o_wr_done and o_wr_err are never high in the same cycle.
- Reset mid-COMMIT: the write is discarded.
- o_cnt saturation: o_cnt never exceeds KEY_NUM.

Optional Feature:
- Macro: LUT_BUILDER_OVERWRITE_EN.
- Defined:
  - In IDLE, the captured key is compared against all valid entries.
  - On a match, COMMIT overwrites the value of the lowest matching index, leaves o_cnt unchanged, and pulses o_wr_done.
  - This succeeds even when o_full=1.
  - Only a non-matching key with o_full=1 produces o_wr_err.
- Undefined: no comparators are built; behaviour is append-only as described above.

Test Plan:
- Reset released, no writes -> o_cnt=0, o_full=0, o_lut=0, o_wr_rdy=1.
- KEY_NUM=4, KEY_WIDTH=4, VAL_WIDTH=8; write (0x3,0xAA) then (0x5,0x55) back-to-back with vld held:
  - rdy toggles 1,0,1,0;
  - o_cnt becomes 1 then 2;
  - o_lut[23:0]=0x555_3AA;
  - two o_wr_done pulses.
- Fill 4 entries, then write (0x9,0x11):
  - o_full=1;
  - o_wr_err pulse, no done;
  - o_lut unchanged;
  - o_cnt=4.
- Assert i_clr during COMMIT of a write:
  - no done/err pulse;
  - next cycle o_cnt=0, o_lut=0, rdy=1.
- With LUT_BUILDER_OVERWRITE_EN, after 4 entries with entry1 key=0x5, write (0x5,0x77):
  - o_wr_done;
  - entry1 value=0x77;
  - o_cnt=4, no err.
- Without the macro, the same write -> o_wr_err.
- Drop i_rst_n mid-COMMIT asynchronously -> all outputs zero immediately, rdy=1 after release.
